// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between a CPU port (0) and a loader/debug port (1).
// Each grant runs IDLE -> ACCESS -> RESP, so one access completes at most every three cycles.
module ram_arbiter #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic [WIDTH-1:0]  wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [WIDTH-1:0]  rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_din,
    output logic              ram_write_en,
    input  logic [WIDTH-1:0]  ram_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   we_r;
    logic   sel;
    logic   last_grant;
    logic   grant;
    logic   winner;

    // On a tie the port that was not served last wins; a lone requester always wins.
    always_comb begin
        grant = req0 | req1;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else begin
            winner = req1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = grant ? ACCESS : IDLE;
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        ram_write_en = (state == ACCESS) && we_r;
        ack0         = (state == RESP) && !sel;
        ack1         = (state == RESP) && sel;
    end

    // rdata samples the RAM before the write lands, giving read-before-write for writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr   <= '0;
            ram_din    <= '0;
            we_r       <= 1'b0;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            rdata      <= '0;
        end else begin
            if (state == IDLE && grant) begin
                ram_addr   <= winner ? addr1 : addr0;
                ram_din    <= winner ? wdata1 : wdata0;
                we_r       <= winner ? we1 : we0;
                sel        <= winner;
                last_grant <= winner;
            end
            if (state == ACCESS) begin
                rdata <= ram_dout;
            end
        end
    end

endmodule
